// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/decode/execute controller for the Salamander-4 ALU.
// Sequences an external ALU against a single accumulator, owns PC, C/Z flags
// and a one-entry return register, and performs LD/ST over a req/ack port.
// Ports:
//   CLK, RST                 clock (rising edge), synchronous active-high reset
//   run                      allow leaving FETCH
//   imem_addr / imem_data    synchronous program ROM (data one cycle after addr)
//   mem_*                    data-memory request/ack port
//   alu_*                    external ALU interface (alu_ce/alu_op/operands out,
//                            alu_result/alu_carry_out in)
//   acc, carry_flag,
//   zero_flag                architectural registers
//   halted, retire           status: in HALT / one pulse per completed instruction
module alu_sequencer #(
  parameter int unsigned SIZE = 8,
  parameter int unsigned PC_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              run,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [4+SIZE-1:0] imem_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [SIZE-1:0]   mem_addr,
  output logic [SIZE-1:0]   mem_wdata,
  input  logic [SIZE-1:0]   mem_rdata,
  input  logic              mem_ack,
  output logic              alu_ce,
  output logic [3:0]        alu_op,
  output logic [SIZE-1:0]   alu_left,
  output logic [SIZE-1:0]   alu_right,
  output logic              alu_carry_in,
  input  logic              alu_carry_out,
  input  logic [SIZE-1:0]   alu_result,
  output logic [SIZE-1:0]   acc,
  output logic              carry_flag,
  output logic              zero_flag,
  output logic              halted,
  output logic              retire
);

  localparam int unsigned IW = 4 + SIZE;

  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_LD  = 4'hA;
  localparam logic [3:0] OP_ST  = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_RTN = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hE;
  localparam logic [3:0] OP_NOP = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  state_t          state, state_n;
  logic [PC_W-1:0] pc, pc_n, ra, ra_n;
  logic            ra_valid, ra_valid_n;
  logic [IW-1:0]   ir, ir_n;
  logic [SIZE-1:0] acc_n;
  logic            c_n, z_n;

  logic [3:0]      opcode;
  logic [SIZE-1:0] imm;
  logic [PC_W-1:0] pc_inc;

  assign opcode = ir[IW-1:SIZE];
  assign imm    = ir[SIZE-1:0];
  assign pc_inc = pc + PC_W'(1);

  // Datapath-facing outputs that are pure wiring of registers
  assign imem_addr    = pc;
  assign mem_addr     = imm;
  assign mem_wdata    = acc;
  assign alu_left     = acc;
  assign alu_carry_in = carry_flag;
  assign halted       = (state == S_HALT);

  // State and architectural registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_FETCH;
      pc         <= '0;
      ir         <= '0;
      acc        <= '0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
      ra         <= '0;
      ra_valid   <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      ir         <= ir_n;
      acc        <= acc_n;
      carry_flag <= c_n;
      zero_flag  <= z_n;
      ra         <= ra_n;
      ra_valid   <= ra_valid_n;
    end
  end

  // Next-state, register updates and cycle-level control outputs
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    ir_n       = ir;
    acc_n      = acc;
    c_n        = carry_flag;
    z_n        = zero_flag;
    ra_n       = ra;
    ra_valid_n = ra_valid;
    alu_ce     = 1'b0;
    alu_op     = OP_NOP;
    alu_right  = imm;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    retire     = 1'b0;

    unique case (state)
      S_FETCH: begin
        if (run) state_n = S_DECODE;
      end

      S_DECODE: begin
        ir_n    = imem_data;
        state_n = S_EXEC;
      end

      S_EXEC: begin
        if (opcode <= OP_SHR) begin
          alu_ce  = 1'b1;
          alu_op  = opcode;
          acc_n   = alu_result;
          c_n     = alu_carry_out;
          z_n     = (alu_result == '0);
          pc_n    = pc_inc;
          retire  = 1'b1;
          state_n = S_FETCH;
        end else begin
          unique case (opcode)
            OP_LD, OP_ST: state_n = S_MEM;
            OP_JMP: begin
              ra_n       = pc_inc;
              ra_valid_n = 1'b1;
              pc_n       = PC_W'(imm);
              retire     = 1'b1;
              state_n    = S_FETCH;
            end
            OP_RTN: begin
              // Empty return register degrades RTN to NOP
              if (ra_valid) begin
                pc_n       = ra;
                ra_valid_n = 1'b0;
              end else begin
                pc_n = pc_inc;
              end
              retire  = 1'b1;
              state_n = S_FETCH;
            end
            OP_HLT: begin
              retire  = 1'b1;
              state_n = S_HALT;
            end
            default: begin
              pc_n    = pc_inc;
              retire  = 1'b1;
              state_n = S_FETCH;
            end
          endcase
        end
      end

      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (opcode == OP_ST);
        if (mem_ack) begin
          alu_ce = 1'b1;
          alu_op = opcode;
          // Loaded data reaches ACC through the ALU pass path; C is preserved
          if (opcode == OP_LD) begin
            alu_right = mem_rdata;
            acc_n     = alu_result;
            z_n       = (alu_result == '0);
          end
          pc_n    = pc_inc;
          retire  = 1'b1;
          state_n = S_FETCH;
        end
      end

      S_HALT: state_n = S_HALT;

      default: state_n = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed testbench for alu_sequencer: program ROM, ALU and data-memory
// responders live here; each task checks one scenario against hand values.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [7:0]  imem_addr;
  logic [11:0] imem_data;
  logic        mem_req, mem_we;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        alu_ce;
  logic [3:0]  alu_op;
  logic [7:0]  alu_left, alu_right;
  logic        alu_carry_in, alu_carry_out;
  logic [7:0]  alu_result;
  logic [7:0]  acc;
  logic        carry_flag, zero_flag, halted, retire;

  logic [11:0] rom [256];
  int          retire_cnt = 0;
  int          pass_cnt   = 0;
  int          total_cnt  = 0;
  int          snap;

  alu_sequencer #(.SIZE(8), .PC_W(8)) dut (
    .CLK(clk), .RST(rst), .run(run),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .alu_ce(alu_ce), .alu_op(alu_op), .alu_left(alu_left),
    .alu_right(alu_right), .alu_carry_in(alu_carry_in),
    .alu_carry_out(alu_carry_out), .alu_result(alu_result),
    .acc(acc), .carry_flag(carry_flag), .zero_flag(zero_flag),
    .halted(halted), .retire(retire)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= rom[imem_addr];

  always @(posedge clk) if (retire) retire_cnt <= retire_cnt + 1;

  // Reference ALU: plain 8-bit ops, carry is carry-out / borrow / shifted-out bit
  always_comb begin
    logic [8:0] t;
    t = {1'b0, alu_left};
    case (alu_op)
      4'h0: t = {1'b0, alu_left} + {1'b0, alu_right};
      4'h1: t = {1'b0, alu_left} - {1'b0, alu_right};
      4'h2: t = {1'b0, alu_left} + 9'd1;
      4'h3: t = {1'b0, alu_left} - 9'd1;
      4'h4: t = {1'b0, alu_left & alu_right};
      4'h5: t = {1'b0, alu_left | alu_right};
      4'h6: t = {1'b0, alu_left ^ alu_right};
      4'h7: t = {1'b0, ~alu_left};
      4'h8: t = {alu_left, 1'b0};
      4'h9: t = {alu_left[0], 1'b0, alu_left[7:1]};
      4'hA: t = {1'b0, alu_right};
      default: t = {1'b0, alu_left};
    endcase
    alu_result    = t[7:0];
    alu_carry_out = t[8];
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_rom(input logic [11:0] fill);
    for (int i = 0; i < 256; i++) rom[i] = fill;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
    step(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_rom(12'h201);
    do_reset();
    run = 1'b1;
    step(5);
    do_reset();
    total_cnt++; if (imem_addr !== 8'h00) $display("FAIL reset_pc got %h want 00", imem_addr); else pass_cnt++;
    total_cnt++; if (acc !== 8'h00) $display("FAIL reset_acc got %h want 00", acc); else pass_cnt++;
    total_cnt++; if ({carry_flag, zero_flag, halted} !== 3'b000) $display("FAIL reset_flags got %b want 000", {carry_flag, zero_flag, halted}); else pass_cnt++;
    total_cnt++; if ({mem_req, alu_ce, retire} !== 3'b000) $display("FAIL reset_ctrl got %b want 000", {mem_req, alu_ce, retire}); else pass_cnt++;
  endtask

  task automatic test_add_halt();
    clear_rom(12'hF00);
    rom[0] = 12'h0F0; rom[1] = 12'h020; rom[2] = 12'hE00;
    do_reset();
    snap = retire_cnt;
    run = 1'b1;
    step(3);
    total_cnt++; if ({carry_flag, acc} !== 9'h0F0) $display("FAIL add1 got c=%b acc=%h want c=0 acc=f0", carry_flag, acc); else pass_cnt++;
    step(3);
    total_cnt++; if ({carry_flag, zero_flag, acc} !== 10'h210) $display("FAIL add2 got c=%b z=%b acc=%h want c=1 z=0 acc=10", carry_flag, zero_flag, acc); else pass_cnt++;
    step(3);
    total_cnt++; if (halted !== 1'b1) $display("FAIL halt got %b want 1", halted); else pass_cnt++;
    total_cnt++; if (imem_addr !== 8'h02) $display("FAIL halt_pc got %h want 02", imem_addr); else pass_cnt++;
    total_cnt++; if (retire_cnt - snap !== 3) $display("FAIL halt_retires got %0d want 3", retire_cnt - snap); else pass_cnt++;
    step(3);
    total_cnt++; if ({halted, imem_addr} !== 9'h102) $display("FAIL halt_hold got %h want 102", {halted, imem_addr}); else pass_cnt++;
  endtask

  task automatic test_zero_flag();
    clear_rom(12'hE00);
    rom[0] = 12'h005; rom[1] = 12'h105; rom[2] = 12'h200;
    do_reset();
    run = 1'b1;
    step(6);
    total_cnt++; if ({carry_flag, zero_flag, acc} !== 10'h100) $display("FAIL sub_zero got c=%b z=%b acc=%h want c=0 z=1 acc=00", carry_flag, zero_flag, acc); else pass_cnt++;
    step(3);
    total_cnt++; if ({zero_flag, acc} !== 9'h001) $display("FAIL inc got z=%b acc=%h want z=0 acc=01", zero_flag, acc); else pass_cnt++;
  endtask

  task automatic test_mem();
    clear_rom(12'hE00);
    rom[0] = 12'h05A; rom[1] = 12'hB40; rom[2] = 12'hA41;
    do_reset();
    run = 1'b1;
    step(3);
    snap = retire_cnt;
    step(3);
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, alu_ce} !== {2'b11, 8'h40, 8'h5A, 1'b0})
        $display("FAIL st_hold%0d got req=%b we=%b addr=%h wdata=%h ce=%b want 1 1 40 5a 0", i, mem_req, mem_we, mem_addr, mem_wdata, alu_ce);
      else pass_cnt++;
      step(1);
    end
    mem_ack = 1'b1;
    #1;
    total_cnt++; if ({retire, alu_ce, alu_op} !== 6'b11_1011) $display("FAIL st_ack got retire=%b ce=%b op=%h want 1 1 b", retire, alu_ce, alu_op); else pass_cnt++;
    step(1);
    mem_ack = 1'b0;
    total_cnt++; if (mem_req !== 1'b0) $display("FAIL st_release got %b want 0", mem_req); else pass_cnt++;
    total_cnt++; if ({acc, imem_addr} !== 16'h5A02) $display("FAIL st_after got acc=%h pc=%h want 5a 02", acc, imem_addr); else pass_cnt++;
    total_cnt++; if (retire_cnt - snap !== 1) $display("FAIL st_retires got %0d want 1", retire_cnt - snap); else pass_cnt++;
    mem_rdata = 8'hC3;
    step(3);
    total_cnt++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 8'h41}) $display("FAIL ld_req got req=%b we=%b addr=%h want 1 0 41", mem_req, mem_we, mem_addr); else pass_cnt++;
    mem_ack = 1'b1;
    step(1);
    mem_ack = 1'b0;
    total_cnt++; if ({zero_flag, acc} !== 9'h0C3) $display("FAIL ld_data got z=%b acc=%h want z=0 acc=c3", zero_flag, acc); else pass_cnt++;
  endtask

  task automatic test_jump();
    logic [7:0] exp_pc [6];
    exp_pc = '{8'h10, 8'h80, 8'h11, 8'h12, 8'hFF, 8'h00};
    clear_rom(12'hF00);
    rom[8'h00] = 12'hC10; rom[8'h10] = 12'hC80; rom[8'h80] = 12'hD00;
    rom[8'h11] = 12'hD00; rom[8'h12] = 12'hCFF; rom[8'hFF] = 12'hF00;
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(3);
      total_cnt++;
      if (imem_addr !== exp_pc[i]) $display("FAIL jump_pc%0d got %h want %h", i, imem_addr, exp_pc[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_stall_and_reset_in_mem();
    clear_rom(12'hE00);
    rom[0] = 12'h200;
    do_reset();
    snap = retire_cnt;
    step(4);
    total_cnt++; if ({imem_addr, acc} !== 16'h0000) $display("FAIL stall_state got pc=%h acc=%h want 00 00", imem_addr, acc); else pass_cnt++;
    total_cnt++; if (retire_cnt - snap !== 0) $display("FAIL stall_retires got %0d want 0", retire_cnt - snap); else pass_cnt++;
    run = 1'b1;
    step(3);
    total_cnt++; if (acc !== 8'h01) $display("FAIL stall_resume got %h want 01", acc); else pass_cnt++;

    clear_rom(12'hE00);
    rom[0] = 12'h077; rom[1] = 12'hA10;
    do_reset();
    run = 1'b1;
    step(6);
    total_cnt++; if (mem_req !== 1'b1) $display("FAIL rstmem_pre got %b want 1", mem_req); else pass_cnt++;
    mem_rdata = 8'h99;
    rst = 1'b1; run = 1'b0;
    step(1);
    rst = 1'b0;
    total_cnt++; if ({mem_req, imem_addr, acc} !== 17'h0_0000) $display("FAIL rstmem_post got req=%b pc=%h acc=%h want 0 00 00", mem_req, imem_addr, acc); else pass_cnt++;
    snap = retire_cnt;
    mem_ack = 1'b1;
    step(2);
    mem_ack = 1'b0;
    total_cnt++; if ({mem_req, acc} !== 9'h000) $display("FAIL stray_ack got req=%b acc=%h want 0 00", mem_req, acc); else pass_cnt++;
    total_cnt++; if (retire_cnt - snap !== 0) $display("FAIL stray_ack_retire got %0d want 0", retire_cnt - snap); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
    clear_rom(12'hF00);
    test_reset();
    test_add_halt();
    test_zero_flag();
    test_mem();
    test_jump();
    test_stall_and_reset_in_mem();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
